serial_adder_nbit: RTL and testbench

//   Bit-serial N-bit adder: one full-adder stage reused over WIDTH clock cycles, LSB first.

---
 rtl/serial_adder_nbit.sv | 113 +++++++++++
 tb/tb_serial_adder_nbit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/serial_adder_nbit.sv
// Bit-serial N-bit adder.
// A single full-adder stage is reused over WIDTH clock cycles, starting at the LSB.
// A start/done handshake drives it. The final sum and carry are registered and
// held until the next done pulse.
module serial_adder_nbit #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_r;
   // sa_r doubles as the result shift register.
   // Each sum bit enters at the MSB as the consumed LSB of A leaves at the bottom.
   logic [WIDTH-1:0]   sa_r;
   logic [WIDTH-1:0]   sb_r;
   logic               carry_r;
   logic [CNT_W-1:0]   count_r;

   logic               bit_s;
   logic               carry_s;
   logic               last_s;

   // Full-adder carry: majority of the three input bits.
   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   // Full-adder sum: odd parity of the three input bits.
   function automatic logic xor3(input logic x, input logic y, input logic z);
      return x ^ y ^ z;
   endfunction

   // Full-adder stage on the current LSBs and detection of the final bit position.
   always_comb begin
      bit_s   = xor3(sa_r[0], sb_r[0], carry_r);
      carry_s = maj3(sa_r[0], sb_r[0], carry_r);
      last_s  = (count_r == CNT_W'(WIDTH - 1));
   end

   // Control FSM, datapath shift registers, and registered handshake/result outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
         sa_r    <= {WIDTH{1'b0}};
         sb_r    <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         count_r <= {CNT_W{1'b0}};
         busy    <= 1'b0;
         done    <= 1'b0;
         sum     <= {WIDTH{1'b0}};
         cout    <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  sa_r    <= a;
                  sb_r    <= b;
                  carry_r <= cin;
                  count_r <= {CNT_W{1'b0}};
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  state_r <= SHIFT;
               end else begin
                  busy    <= 1'b0;
                  done    <= 1'b0;
                  state_r <= IDLE;
               end
            end
            SHIFT: begin
               // start is deliberately ignored here: no queueing, no restart.
               sa_r    <= {bit_s, sa_r[WIDTH-1:1]};
               sb_r    <= {1'b0, sb_r[WIDTH-1:1]};
               carry_r <= carry_s;
               count_r <= count_r + CNT_W'(1);
               if (last_s) begin
                  sum     <= {bit_s, sa_r[WIDTH-1:1]};
                  cout    <= carry_s;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_r <= DONE;
               end else begin
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  state_r <= SHIFT;
               end
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Directed self-checking bench for serial_adder_nbit (WIDTH=4).
// Expected sums and carries are hand-computed constants.
module tb_serial_adder_nbit;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic       busy;
   logic       done;
   logic [3:0] sum;
   logic       cout;

   int errors = 0;
   int checks = 0;

   serial_adder_nbit #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One isolated operation.
   // Checks busy for 4 cycles, then the done pulse and the result, then that done falls.
   task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_in, input logic tc,
                        input logic [3:0] es, input logic ec, input string tag);
      a = ta; b = tb_in; cin = tc; start = 1'b1;
      step();
      start = 1'b0;
      a = ~ta; b = ~tb_in; cin = ~tc;
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_busy"}, 32'(busy), 32'd1);
         chk({tag, "_nodone"}, 32'(done), 32'd0);
         step();
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
      chk({tag, "_sum"}, 32'(sum), 32'(es));
      chk({tag, "_cout"}, 32'(cout), 32'(ec));
      step();
      chk({tag, "_done_fall"}, 32'(done), 32'd0);
      chk({tag, "_sum_hold"}, 32'(sum), 32'(es));
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; a = 4'd0; b = 4'd0; cin = 1'b0;
      step();
      step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      rst_n = 1'b1;
      step();

      do_op(4'd6, 4'd9, 1'b0, 4'd15, 1'b0, "t1_6p9");
      do_op(4'd12, 4'd7, 1'b0, 4'd3, 1'b1, "t2_12p7");
      do_op(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, "t2_15p15c");
      do_op(4'b1010, 4'd10, 1'b0, 4'd4, 1'b1, "t3_inverse");

      // Test 4: a start pulse during SHIFT must be ignored.
      a = 4'd3; b = 4'd4; cin = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step();
      a = 4'd9; b = 4'd9; start = 1'b1;
      step();
      start = 1'b0;
      chk("t4_busy_mid", 32'(busy), 32'd1);
      step();
      step();
      chk("t4_done", 32'(done), 32'd1);
      chk("t4_sum", 32'(sum), 32'd7);
      chk("t4_cout", 32'(cout), 32'd0);
      step();
      chk("t4_idle_busy", 32'(busy), 32'd0);

      // Test 5: start held high gives back-to-back operations.
      a = 4'd1; b = 4'd1; cin = 1'b0; start = 1'b1;
      step();
      a = 4'd2; b = 4'd2;
      for (int i = 0; i < 4; i++) step();
      chk("t5_done1", 32'(done), 32'd1);
      chk("t5_sum1", 32'(sum), 32'd2);
      step();
      chk("t5_done1_fall", 32'(done), 32'd0);
      chk("t5_busy2", 32'(busy), 32'd1);
      chk("t5_sum_hold_a", 32'(sum), 32'd2);
      step();
      step();
      chk("t5_sum_hold_b", 32'(sum), 32'd2);
      chk("t5_nodone_mid", 32'(done), 32'd0);
      step();
      step();
      chk("t5_done2", 32'(done), 32'd1);
      chk("t5_sum2", 32'(sum), 32'd4);
      chk("t5_cout2", 32'(cout), 32'd0);
      start = 1'b0;
      step();
      chk("t5_end_done", 32'(done), 32'd0);
      chk("t5_end_busy", 32'(busy), 32'd0);

      // Test 6: synchronous reset mid-SHIFT aborts and clears the outputs.
      a = 4'd5; b = 4'd6; cin = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_done", 32'(done), 32'd0);
      chk("t6_sum", 32'(sum), 32'd0);
      chk("t6_cout", 32'(cout), 32'd0);
      rst_n = 1'b1;
      step();
      do_op(4'd5, 4'd6, 1'b1, 4'd12, 1'b0, "t6_fresh");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
